// File: rtl/dpram_pkg.sv
// Shared types and helpers for the true dual-port byte-write RAM.
//   write_mode_e : per-port behaviour of dout on a cycle where that port writes
//   ram_state_e  : CLEAR/RUN states of the post-reset clear sequencer
//   merge_bytes  : lane-merges a new word into an old word under a byte-enable mask
package dpram_pkg;

  typedef enum logic [1:0] {
    WM_WRITE_FIRST,
    WM_READ_FIRST,
    WM_NO_CHANGE
  } write_mode_e;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } ram_state_e;

  // Widest word merge_bytes can handle; callers zero-extend into this width.
  localparam int MERGE_MAX_W = 512;

  // Bit b of the result comes from new_word when the enable of its lane is set.
  function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_W-1:0] we,
    input int                     byte_w
  );
    logic [MERGE_MAX_W-1:0] res;
    for (int b = 0; b < MERGE_MAX_W; b++) begin
      res[b] = we[b / byte_w] ? new_word[b] : old_word[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline: LATENCY register stages carrying a valid bit and data.
//   clk, rst : clock, synchronous active-high reset (flushes every stage)
//   v_i, d_i : read issued this cycle and the word it returns
//   v_o, d_o : valid pulse and data, LATENCY cycles after v_i; d_o holds between pulses
module ram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  v_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic                  v_o,
  output logic [DATA_WIDTH-1:0] d_o
);

  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("ram_rd_pipe: LATENCY must be 1..3");
  end

  logic [LATENCY-1:0]    v_q;
  logic [DATA_WIDTH-1:0] d_q [LATENCY];

  // Data stages load only behind a valid bit, so the last stage holds the
  // most recent read result between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < LATENCY; k++) d_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the pre-edge
      // value of the previous one, which is what gives a shift register.
      v_q[0] <= v_i;
      if (v_i) d_q[0] <= d_i;
      for (int k = 1; k < LATENCY; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) d_q[k] <= d_q[k-1];
      end
    end
  end

  assign v_o = v_q[LATENCY-1];
  assign d_o = d_q[LATENCY-1];

endmodule

// File: rtl/tdp_ram_bytewr.sv
// True dual-port RAM with per-byte write enables, per-port write mode and
// per-port read latency, plus a post-reset clear sequencer and collision flag.
//   clk, rst        : clock, synchronous active-high reset
//   init_busy       : clear sequence running; port requests are dropped
//   ena/enb         : port enable
//   wea/web         : byte write enables (all zero = read)
//   addra/addrb     : word address
//   dina/dinb       : write data
//   douta/doutb     : read data, held between valid pulses
//   va/vb           : read data valid pulse
//   collision       : same-address write conflict, flagged one cycle later
module tdp_ram_bytewr
  import dpram_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int          BYTE_WIDTH     = 8,
  parameter int          SIZE           = 1024,
  parameter int          LATENCY_A      = 1,
  parameter int          LATENCY_B      = 1,
  parameter write_mode_e WRITE_MODE_A   = WM_WRITE_FIRST,
  parameter write_mode_e WRITE_MODE_B   = WM_WRITE_FIRST,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int         NB             = DATA_WIDTH / BYTE_WIDTH,
  localparam int         AW             = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  ena,
  input  logic [NB-1:0]         wea,
  input  logic [AW-1:0]         addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  va,
  input  logic                  enb,
  input  logic [NB-1:0]         web,
  input  logic [AW-1:0]         addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  vb,
  output logic                  collision
);

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("tdp_ram_bytewr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (DATA_WIDTH > MERGE_MAX_W) begin : g_too_wide
    $error("tdp_ram_bytewr: DATA_WIDTH exceeds MERGE_MAX_W");
  end
  if (LATENCY_A < 1 || LATENCY_A > 3 || LATENCY_B < 1 || LATENCY_B > 3) begin : g_bad_lat
    $error("tdp_ram_bytewr: LATENCY_A/LATENCY_B must be 1..3");
  end

  // NOTE: the array has no reset branch; a reset loop over every word would
  // stop it mapping to block RAM. The clear sequencer zeroes it instead.
  logic [DATA_WIDTH-1:0] mem [SIZE];

  ram_state_e            state_q;
  logic [AW-1:0]         clr_addr_q;
  logic                  collision_q;

  logic                  acc_a, acc_b, wr_a, wr_b, same_addr;
  logic [DATA_WIDTH-1:0] old_a, old_b, merged_a, fin_a, fin_b;
  logic                  rd_issue_a, rd_issue_b;
  logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;

  // Busy is asserted combinationally during rst so no request slips in
  // before the state register has been forced to CLEAR.
  assign init_busy = rst ? CLEAR_ON_RESET : (state_q == ST_CLEAR);
  assign acc_a     = ena & ~init_busy & ~rst;
  assign acc_b     = enb & ~init_busy & ~rst;
  assign wr_a      = |wea;
  assign wr_b      = |web;
  assign same_addr = acc_a & acc_b & (addra == addrb);

  assign old_a    = mem[addra];
  assign old_b    = mem[addrb];
  assign merged_a = DATA_WIDTH'(merge_bytes(MERGE_MAX_W'(old_a), MERGE_MAX_W'(dina),
                                            MERGE_MAX_W'(wea), BYTE_WIDTH));
  // On a shared address the final word is A's merge overlaid by B's lanes,
  // matching the write order below where B's lane writes land last.
  assign fin_a = same_addr
               ? DATA_WIDTH'(merge_bytes(MERGE_MAX_W'(merged_a), MERGE_MAX_W'(dinb),
                                         MERGE_MAX_W'(web), BYTE_WIDTH))
               : merged_a;
  assign fin_b = same_addr
               ? fin_a
               : DATA_WIDTH'(merge_bytes(MERGE_MAX_W'(old_b), MERGE_MAX_W'(dinb),
                                         MERGE_MAX_W'(web), BYTE_WIDTH));

  // A read-only port always returns the pre-write word; a writing port
  // returns per its mode, and NO_CHANGE issues no read at all.
  assign rd_issue_a = acc_a & ~(wr_a & (WRITE_MODE_A == WM_NO_CHANGE));
  assign rd_issue_b = acc_b & ~(wr_b & (WRITE_MODE_B == WM_NO_CHANGE));
  assign rd_data_a  = (wr_a && WRITE_MODE_A == WM_WRITE_FIRST) ? fin_a : old_a;
  assign rd_data_b  = (wr_b && WRITE_MODE_B == WM_WRITE_FIRST) ? fin_b : old_b;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem[clr_addr_q] <= '0;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (acc_a && wea[i])
            mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        // Port B lanes are written after port A, so B wins overlapping lanes.
        for (int i = 0; i < NB; i++) begin
          if (acc_b && web[i])
            mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Clear sequencer: one zero word per cycle, RUN after the last address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_addr_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      if (clr_addr_q == AW'(SIZE - 1)) state_q <= ST_RUN;
      clr_addr_q <= clr_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) collision_q <= 1'b0;
    else     collision_q <= same_addr & (wr_a | wr_b);
  end
  assign collision = collision_q;

  ram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY_A)) u_pipe_a (
    .clk (clk), .rst (rst), .v_i (rd_issue_a), .d_i (rd_data_a), .v_o (va), .d_o (douta)
  );

  ram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .LATENCY(LATENCY_B)) u_pipe_b (
    .clk (clk), .rst (rst), .v_i (rd_issue_b), .d_i (rd_data_b), .v_o (vb), .d_o (doutb)
  );

endmodule

// File: tb/tb_tdp_ram_bytewr.sv
// Self-checking bench for tdp_ram_bytewr. Two instances share one stimulus
// stream and differ in write modes and latencies:
//   dut1: A WRITE_FIRST lat 1, B READ_FIRST lat 3
//   dut2: A NO_CHANGE   lat 2, B WRITE_FIRST lat 1
// A reference memory predicts every read; predictions are queued with their
// due cycle and compared when the checker reaches that cycle.
module tb_tdp_ram_bytewr;
  import dpram_pkg::*;

  localparam int DW = 32, NB = 4, SIZE = 16, AW = 4;
  localparam int LAT_A1 = 1, LAT_B1 = 3, LAT_A2 = 2, LAT_B2 = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena, enb;
  logic [NB-1:0] wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb;

  logic          busy1, va1, vb1, coll1, busy2, va2, vb2, coll2;
  logic [DW-1:0] douta1, doutb1, douta2, doutb2;

  always #5 clk = ~clk;

  tdp_ram_bytewr #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(8), .SIZE(SIZE), .LATENCY_A(LAT_A1), .LATENCY_B(LAT_B1),
    .WRITE_MODE_A(WM_WRITE_FIRST), .WRITE_MODE_B(WM_READ_FIRST), .CLEAR_ON_RESET(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .init_busy(busy1),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .va(va1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .vb(vb1),
    .collision(coll1)
  );

  tdp_ram_bytewr #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(8), .SIZE(SIZE), .LATENCY_A(LAT_A2), .LATENCY_B(LAT_B2),
    .WRITE_MODE_A(WM_NO_CHANGE), .WRITE_MODE_B(WM_WRITE_FIRST), .CLEAR_ON_RESET(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst), .init_busy(busy2),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta2), .va(va2),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb2), .vb(vb2),
    .collision(coll2)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_exp_t;

  typedef struct {
    int   due;
    logic val;
  } coll_exp_t;

  // Port ids: 0 = dut1.A, 1 = dut1.B, 2 = dut2.A, 3 = dut2.B
  rd_exp_t       exp_q [4][$];
  coll_exp_t     coll_q[$];
  logic [DW-1:0] last_d [4];
  logic [DW-1:0] mem_m [SIZE];
  int            m_clr_left;
  int            cyc = 0;
  logic          rst_seen = 1'b0;
  bit            chk_en = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_port(input int p, input string tag, input logic v, input logic [DW-1:0] d);
    if (rst_seen) last_d[p] = '0;
    if (exp_q[p].size() > 0 && exp_q[p][0].due == cyc) begin
      check({tag, ".v"}, DW'(v), DW'(1));
      check({tag, ".dout"}, d, exp_q[p][0].data);
      last_d[p] = exp_q[p][0].data;
      void'(exp_q[p].pop_front());
    end else begin
      check({tag, ".v"}, DW'(v), DW'(0));
      check({tag, ".hold"}, d, last_d[p]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_port(0, "dut1.A", va1, douta1);
      check_port(1, "dut1.B", vb1, doutb1);
      check_port(2, "dut2.A", va2, douta2);
      check_port(3, "dut2.B", vb2, doutb2);
      if (coll_q.size() > 0 && coll_q[0].due == cyc) begin
        check("dut1.collision", DW'(coll1), DW'(coll_q[0].val));
        check("dut2.collision", DW'(coll2), DW'(coll_q[0].val));
        void'(coll_q.pop_front());
      end
    end
  end

  task automatic push_read(input int p, input logic en, input logic wr, input write_mode_e mode,
                           input logic [DW-1:0] old_w, input logic [DW-1:0] fin_w, input int due);
    rd_exp_t e;
    if (en && !(wr && mode == WM_NO_CHANGE)) begin
      e.due  = due;
      e.data = (wr && mode == WM_WRITE_FIRST) ? fin_w : old_w;
      exp_q[p].push_back(e);
    end
  endtask

  // One clock cycle: check init_busy, drive inputs, update the model, advance.
  // Called 2 time units after a rising edge.
  task automatic step(input logic r,
                      input logic ea, input logic [NB-1:0] wa, input logic [AW-1:0] aa,
                      input logic [DW-1:0] da,
                      input logic eb, input logic [NB-1:0] wb, input logic [AW-1:0] ab,
                      input logic [DW-1:0] db);
    logic          exp_busy;
    logic [DW-1:0] old_a, old_b, fin_a, fin_b;
    coll_exp_t     c;
    int            n;
    exp_busy = (rst === 1'b1) || (m_clr_left > 0);
    check("dut1.init_busy", DW'(busy1), DW'(exp_busy));
    check("dut2.init_busy", DW'(busy2), DW'(exp_busy));
    rst = r; ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    n     = cyc;
    c.due = n + 1;
    c.val = 1'b0;
    if (r) begin
      m_clr_left = SIZE;
      for (int p = 0; p < 4; p++)
        while (exp_q[p].size() > 0 && exp_q[p][$].due > n) void'(exp_q[p].pop_back());
    end else if (m_clr_left > 0) begin
      mem_m[SIZE - m_clr_left] = '0;
      m_clr_left--;
    end else begin
      old_a = mem_m[aa];
      old_b = mem_m[ab];
      for (int i = 0; i < NB; i++) if (ea && wa[i]) mem_m[aa][i*8 +: 8] = da[i*8 +: 8];
      for (int i = 0; i < NB; i++) if (eb && wb[i]) mem_m[ab][i*8 +: 8] = db[i*8 +: 8];
      fin_a = mem_m[aa];
      fin_b = mem_m[ab];
      push_read(0, ea, |wa, WM_WRITE_FIRST, old_a, fin_a, n + LAT_A1);
      push_read(1, eb, |wb, WM_READ_FIRST,  old_b, fin_b, n + LAT_B1);
      push_read(2, ea, |wa, WM_NO_CHANGE,   old_a, fin_a, n + LAT_A2);
      push_read(3, eb, |wb, WM_WRITE_FIRST, old_b, fin_b, n + LAT_B2);
      c.val = ea && eb && (aa == ab) && ((|wa) || (|wb));
    end
    coll_q.push_back(c);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    for (int p = 0; p < 4; p++) last_d[p] = '0;
    m_clr_left = SIZE;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;

    // Initial clear: busy for SIZE cycles after rst drops, then RUN.
    idle(SIZE + 1);

    // Fill with non-zero so a later clear is observable.
    for (int i = 0; i < SIZE; i++)
      step(1'b0, 1'b1, 4'hF, AW'(i), 32'hC0DE_0000 | DW'(i), 1'b0, '0, '0, '0);

    // Reset, interrupt the clear at cycle 8, restart; requests meanwhile are dropped.
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, '0, AW'(i), '0, 1'b1, 4'hF, AW'(15 - i), 32'hDEAD_BEEF);
    step(1'b1, 1'b1, '0, '0, '0, 1'b0, '0, '0, '0);
    for (int i = 0; i < SIZE; i++)
      step(1'b0, 1'b1, 4'hF, AW'(i), 32'h5555_5555, 1'b1, '0, AW'(i), '0);
    idle(1);

    // Every address reads zero on both ports, back to back.
    for (int i = 0; i < SIZE; i++)
      step(1'b0, 1'b1, '0, AW'(i), '0, 1'b1, '0, AW'(SIZE - 1 - i), '0);

    // Byte-lane merge.
    step(1'b0, 1'b1, 4'hF,    4'd5, 32'hAABB_CCDD, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 4'b0010, 4'd5, 32'h0000_1100, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, '0,      4'd5, '0,            1'b0, '0, '0, '0);

    // Write modes on address 3.
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'hF, 4'd3, 32'h2222_2222);
    step(1'b0, 1'b1, 4'hF, 4'd3, 32'h1111_1111, 1'b0, '0, '0, '0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'hF, 4'd3, 32'h3333_3333);
    idle(1);

    // Collisions: full write/write, partial lanes, read/read, read vs write.
    step(1'b0, 1'b1, 4'hF, 4'd7, 32'h0000_00FF, 1'b1, 4'hF, 4'd7, 32'hFFFF_0000);
    step(1'b0, 1'b1, '0,   4'd7, '0,            1'b0, '0,   '0,   '0);
    step(1'b0, 1'b1, 4'b0011, 4'd9, 32'h1234_5678, 1'b1, 4'b0110, 4'd9, 32'hAAAA_AAAA);
    step(1'b0, 1'b1, '0, 4'd9, '0, 1'b1, '0, 4'd9, '0);
    step(1'b0, 1'b1, '0, 4'd9, '0, 1'b1, 4'b1000, 4'd9, 32'h5500_0000);
    step(1'b0, 1'b1, '0, 4'd9, '0, 1'b0, '0, '0, '0);

    // Preload 0..9, then ten back-to-back reads on port B.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 4'hF, AW'(i), DW'(i), 1'b0, '0, '0, '0);
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b0, '0, '0, '0, 1'b1, '0, AW'(i), '0);
    idle(4);

    // Random traffic on both ports, frequent address overlap.
    for (int i = 0; i < 300; i++) begin
      logic [NB-1:0] wa_r, wb_r;
      wa_r = ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom_range(0, 15));
      wb_r = ($urandom_range(0, 1) == 0) ? '0 : NB'($urandom_range(0, 15));
      step(1'b0, 1'($urandom_range(0, 1)), wa_r, AW'($urandom_range(0, 3)), DW'($urandom),
                 1'($urandom_range(0, 1)), wb_r, AW'($urandom_range(0, 3)), DW'($urandom));
    end

    // Reset with reads in flight: pipelines flush, no late pulses.
    step(1'b0, 1'b1, '0, 4'd2, '0, 1'b1, '0, 4'd3, '0);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    idle(SIZE + 4);

    for (int p = 0; p < 4; p++) check("drain", DW'(exp_q[p].size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
